// File: rtl/cpu_pkg.sv
// Shared types for the teaching CPU control path.
// Contents: opcode/T-state encodings, the control word carried from the
// decoder to the sequencer outputs, and the all-zero control word.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned TSTATE_W = 3;
  localparam int unsigned NUM_T    = 6;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_JMP = 4'b0011,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_t;

  typedef enum logic [TSTATE_W-1:0] {
    TS_IDLE = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_T3   = 3'd3,
    TS_T4   = 3'd4,
    TS_T5   = 3'd5,
    TS_T6   = 3'd6,
    TS_HALT = 3'd7
  } tstate_t;

  typedef struct packed {
    logic pc_out;
    logic pc_en;
    logic pc_load;
    logic mar_load;
    logic ram_oe;
    logic ir_load;
    logic ir_oe;
    logic a_load;
    logic a_oe;
    logic b_load;
    logic alu_oe;
    logic sub;
    logic out_load;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode from T-state and opcode.
// Ports: tstate (current T-state), opcode (IR upper nibble, only used in
// T4..T6), ctrl (the 13 datapath strobes).
module control_decode
  import cpu_pkg::*;
(
  input  tstate_t    tstate,
  input  opcode_t    opcode,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (tstate)
      TS_T1: begin
        ctrl.pc_out   = 1'b1;
        ctrl.mar_load = 1'b1;
      end
      TS_T2: ctrl.pc_en = 1'b1;
      TS_T3: begin
        ctrl.ram_oe  = 1'b1;
        ctrl.ir_load = 1'b1;
      end
      TS_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl.ir_oe    = 1'b1;
            ctrl.mar_load = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_oe   = 1'b1;
            ctrl.pc_load = 1'b1;
          end
          OP_OUT: begin
            ctrl.a_oe     = 1'b1;
            ctrl.out_load = 1'b1;
          end
          default: ctrl = CTRL_NONE;
        endcase
      end
      TS_T5: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_oe = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_oe = 1'b1;
            ctrl.b_load = 1'b1;
          end
          default: ctrl = CTRL_NONE;
        endcase
      end
      TS_T6: begin
        case (opcode)
          OP_ADD: begin
            ctrl.alu_oe = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_SUB: begin
            ctrl.alu_oe = 1'b1;
            ctrl.a_load = 1'b1;
            ctrl.sub    = 1'b1;
          end
          default: ctrl = CTRL_NONE;
        endcase
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Six-cycle fetch/execute sequencer for the 8-bit teaching CPU.
// Ports: CLK, RESET (async, active-high), run (start/continue level),
// opcode (IR upper nibble), t_state (IDLE=0, T1..T6, HALT=7), the 13
// datapath strobes, hlt (held in HALT) and instr_done (T6 pulse).
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [TSTATE_W-1:0] t_state,
  output logic                pc_out,
  output logic                pc_en,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_oe,
  output logic                ir_load,
  output logic                ir_oe,
  output logic                a_load,
  output logic                a_oe,
  output logic                b_load,
  output logic                alu_oe,
  output logic                sub,
  output logic                out_load,
  output logic                hlt,
  output logic                instr_done
);

  tstate_t    state;
  tstate_t    state_next;
  ctrl_word_t ctrl;

  // State register; reset forces IDLE, which decodes to all-zero strobes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= TS_IDLE;
    else       state <= state_next;
  end

  // Next-state: fixed walk, HLT diverts from T4, HALT is terminal.
  always_comb begin
    state_next = state;
    case (state)
      TS_IDLE: state_next = run ? TS_T1 : TS_IDLE;
      TS_T1:   state_next = TS_T2;
      TS_T2:   state_next = TS_T3;
      TS_T3:   state_next = TS_T4;
      TS_T4:   state_next = (opcode_t'(opcode) == OP_HLT) ? TS_HALT : TS_T5;
      TS_T5:   state_next = TS_T6;
      TS_T6:   state_next = run ? TS_T1 : TS_IDLE;
      TS_HALT: state_next = TS_HALT;
      default: state_next = TS_IDLE;
    endcase
  end

  control_decode u_decode (
    .tstate (state),
    .opcode (opcode_t'(opcode)),
    .ctrl   (ctrl)
  );

  // Output decode: strobes from the decoder, status bits from state alone.
  always_comb begin
    t_state    = TSTATE_W'(state);
    pc_out     = ctrl.pc_out;
    pc_en      = ctrl.pc_en;
    pc_load    = ctrl.pc_load;
    mar_load   = ctrl.mar_load;
    ram_oe     = ctrl.ram_oe;
    ir_load    = ctrl.ir_load;
    ir_oe      = ctrl.ir_oe;
    a_load     = ctrl.a_load;
    a_oe       = ctrl.a_oe;
    b_load     = ctrl.b_load;
    alu_oe     = ctrl.alu_oe;
    sub        = ctrl.sub;
    out_load   = ctrl.out_load;
    hlt        = (state == TS_HALT);
    instr_done = (state == TS_T6);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a cycle model pushes the
// expected output vector per cycle into a scoreboard queue; each scenario
// task pops and compares on the falling edge.
module tb_control_sequencer;

  logic       CLK;
  logic       RESET;
  logic       run;
  logic [3:0] opcode;
  logic [2:0] t_state;
  logic pc_out, pc_en, pc_load, mar_load, ram_oe, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, sub, out_load, hlt, instr_done;

  control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .run(run), .opcode(opcode), .t_state(t_state),
    .pc_out(pc_out), .pc_en(pc_en), .pc_load(pc_load), .mar_load(mar_load),
    .ram_oe(ram_oe), .ir_load(ir_load), .ir_oe(ir_oe), .a_load(a_load),
    .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe), .sub(sub),
    .out_load(out_load), .hlt(hlt), .instr_done(instr_done)
  );

  // {t_state, hlt, instr_done, 13 strobes}
  logic [17:0] obs;
  logic [4:0]  bus;
  assign obs = {t_state, hlt, instr_done, pc_out, pc_en, pc_load, mar_load,
                ram_oe, ir_load, ir_oe, a_load, a_oe, b_load, alu_oe, sub,
                out_load};
  assign bus = {pc_out, ram_oe, ir_oe, a_oe, alu_oe};

  localparam logic [12:0] S_PC_OUT = 13'd1 << 12;
  localparam logic [12:0] S_PC_EN  = 13'd1 << 11;
  localparam logic [12:0] S_PC_LD  = 13'd1 << 10;
  localparam logic [12:0] S_MAR    = 13'd1 << 9;
  localparam logic [12:0] S_RAM_OE = 13'd1 << 8;
  localparam logic [12:0] S_IR_LD  = 13'd1 << 7;
  localparam logic [12:0] S_IR_OE  = 13'd1 << 6;
  localparam logic [12:0] S_A_LD   = 13'd1 << 5;
  localparam logic [12:0] S_A_OE   = 13'd1 << 4;
  localparam logic [12:0] S_B_LD   = 13'd1 << 3;
  localparam logic [12:0] S_ALU_OE = 13'd1 << 2;
  localparam logic [12:0] S_SUB    = 13'd1 << 1;
  localparam logic [12:0] S_OUT_LD = 13'd1;

  int          errors = 0;
  int          checks = 0;
  int          mstate = 0;
  logic [17:0] exp_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [17:0] model_out(input int st, input logic [3:0] op);
    logic [12:0] s;
    s = '0;
    case (st)
      1: s = S_PC_OUT | S_MAR;
      2: s = S_PC_EN;
      3: s = S_RAM_OE | S_IR_LD;
      4: begin
        if (op == 4'd0 || op == 4'd1 || op == 4'd2) s = S_IR_OE | S_MAR;
        else if (op == 4'd3)  s = S_IR_OE | S_PC_LD;
        else if (op == 4'd14) s = S_A_OE | S_OUT_LD;
      end
      5: begin
        if (op == 4'd0) s = S_RAM_OE | S_A_LD;
        else if (op == 4'd1 || op == 4'd2) s = S_RAM_OE | S_B_LD;
      end
      6: begin
        if (op == 4'd1) s = S_ALU_OE | S_A_LD;
        else if (op == 4'd2) s = S_ALU_OE | S_A_LD | S_SUB;
      end
      default: s = '0;
    endcase
    return {3'(st), 1'(st == 7), 1'(st == 6), s};
  endfunction

  function automatic int model_next(input int st, input logic r, input logic [3:0] op);
    case (st)
      0:       return r ? 1 : 0;
      4:       return (op == 4'd15) ? 7 : 5;
      6:       return r ? 1 : 0;
      7:       return 7;
      default: return st + 1;
    endcase
  endfunction

  // Drive one cycle of stimulus just after a rising edge, record the
  // expected outputs, and wait for the falling edge to sample.
  task automatic drive(input logic r, input logic [3:0] op);
    run    = r;
    opcode = op;
    exp_q.push_back(model_out(mstate, op));
    @(negedge CLK);
  endtask

  task automatic tick();
    @(posedge CLK);
    mstate = model_next(mstate, run, opcode);
    #1;
  endtask

  function automatic logic [3:0] pick_op(input logic [3:0] op);
    if (mstate >= 4 && mstate <= 6) return op;
    return 4'($urandom_range(15));
  endfunction

  task automatic test_reset();
    RESET = 1'b1; run = 1'b0; opcode = 4'd0;
    #3;
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL reset_pre_clk got=%h exp=%h", obs, 18'h0); end
    run = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL reset_held got=%h exp=%h", obs, 18'h0); end
    RESET = 1'b0; run = 1'b0;
    mstate = 0;
  endtask

  task automatic test_program();
    logic [3:0]  seq [4];
    logic [17:0] e;
    logic        r;
    int          k, n_sub, last_done;
    seq = '{4'd0, 4'd1, 4'd2, 4'd14};
    k = 0; n_sub = 0; last_done = -1;
    for (int i = 0; i < 26; i++) begin
      r = (i < 25) && !(mstate == 6 && k == 3);
      drive(r, pick_op((k < 4) ? seq[k] : 4'd0));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL prog cyc=%0d got=%h exp=%h", i, obs, e); end
      checks++;
      if ($countones(bus) > 1) begin errors++; $display("FAIL prog_bus cyc=%0d drivers=%0d exp<=1", i, $countones(bus)); end
      if (sub) n_sub++;
      if (instr_done) begin
        if (last_done >= 0) begin
          checks++;
          if (i - last_done != 6) begin errors++; $display("FAIL prog_done_period got=%0d exp=6", i - last_done); end
        end
        last_done = i;
      end
      if (mstate == 6) k++;
      tick();
    end
    checks++;
    if (n_sub != 1) begin errors++; $display("FAIL prog_sub_count got=%0d exp=1", n_sub); end
  endtask

  task automatic test_jmp();
    logic [17:0] e;
    int          n_pc_en;
    n_pc_en = 0;
    for (int i = 0; i < 8; i++) begin
      drive(!(mstate == 6) && i < 7, pick_op(4'd3));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL jmp cyc=%0d got=%h exp=%h", i, obs, e); end
      if (mstate >= 4 && mstate <= 6 && pc_en) n_pc_en++;
      tick();
    end
    checks++;
    if (n_pc_en != 0) begin errors++; $display("FAIL jmp_pc_en got=%0d exp=0", n_pc_en); end
  endtask

  task automatic test_run_drop();
    logic [17:0] e;
    int          n_done;
    n_done = 0;
    for (int i = 0; i < 9; i++) begin
      drive(i < 2, pick_op(4'd0));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL drop cyc=%0d got=%h exp=%h", i, obs, e); end
      if (instr_done) n_done++;
      tick();
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL drop_done_count got=%0d exp=1", n_done); end
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL drop_idle got=%h exp=%h", obs, 18'h0); end
  endtask

  task automatic test_nop();
    logic [17:0] e;
    int          n_done;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      drive(!(mstate == 6 && i > 7) && i < 13, pick_op(4'd5));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL nop cyc=%0d got=%h exp=%h", i, obs, e); end
      checks++;
      if ($countones(bus) > 1) begin errors++; $display("FAIL nop_bus cyc=%0d drivers=%0d exp<=1", i, $countones(bus)); end
      if (instr_done) n_done++;
      tick();
    end
    checks++;
    if (n_done != 2) begin errors++; $display("FAIL nop_done_count got=%0d exp=2", n_done); end
  endtask

  task automatic test_async_reset();
    logic [17:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, pick_op(4'd1));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL areset_pre cyc=%0d got=%h exp=%h", i, obs, e); end
      if (i < 5) tick();
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL areset_immediate got=%h exp=%h", obs, 18'h0); end
    mstate = 0;
    #2;
    RESET = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(!(mstate == 6), pick_op(4'd1));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL areset_post cyc=%0d got=%h exp=%h", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_hlt();
    logic [17:0] e;
    int          k;
    k = 0;
    for (int i = 0; i < 31; i++) begin
      drive((mstate == 7) ? 1'(i % 2) : 1'b1, pick_op((k == 0) ? 4'd0 : 4'd15));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL hlt cyc=%0d got=%h exp=%h", i, obs, e); end
      if (mstate == 7) begin
        checks++;
        if (t_state !== 3'd7 || hlt !== 1'b1) begin
          errors++; $display("FAIL hlt_hold cyc=%0d t_state=%0d hlt=%b exp 7/1", i, t_state, hlt);
        end
      end
      if (mstate == 6) k++;
      tick();
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL hlt_reset got=%h exp=%h", obs, 18'h0); end
    mstate = 0;
    #2;
    RESET = 1'b0;
    tick();
    drive(1'b0, 4'd0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL hlt_after_reset got=%h exp=%h", obs, e); end
    tick();
  endtask

  initial begin
    test_reset();
    test_program();
    test_jmp();
    test_run_drop();
    test_nop();
    test_async_reset();
    test_hlt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
